// File: rtl/spi_slave_ctrl.sv
// ----------------------------------------------------------------------------
// spi_slave_ctrl
//   SPI target controller. The SPI pins are oversampled on core_clk through
//   synchronizers and edge-detected, so nothing is clocked by SCLK. One
//   DATA_W-bit word is exchanged per chip-select assertion, MSB first, in all
//   four CPOL/CPHA modes.
//
// Ports
//   core_clk, srst        : processing clock, synchronous active-high reset
//   enable                : accept frames (sampled at a CS falling edge)
//   cpol_cpha             : [1]=CPOL, [0]=CPHA, latched at a CS falling edge
//   tx_data/valid/ready   : TX word handshake into a one-entry holding register
//   rx_data/valid/ready   : RX word handshake out
//   err_clr               : clears error_flags
//   spi_cs_n/sclk/mosi    : SPI pins, asynchronous to core_clk
//   spi_miso, spi_miso_oe : serial data out and its output enable
//   busy                  : controller not idle
//   error_flags           : sticky [0] RX overrun, [1] TX underrun,
//                           [2] frame abort, [3] always 0
// ----------------------------------------------------------------------------
module spi_slave_ctrl #(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              core_clk,
  input  logic              srst,
  input  logic              enable,
  input  logic [1:0]        cpol_cpha,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic              err_clr,
  input  logic              spi_cs_n,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              busy,
  output logic [3:0]        error_flags
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE,
    ST_WAIT_CS
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;

  logic [SYNC_STAGES-1:0]   r_cs_sync;
  logic [SYNC_STAGES-1:0]   r_sclk_sync;
  logic [SYNC_STAGES-1:0]   r_mosi_sync;
  logic [SYNC_STAGES-1:0]   r_sync_vld;
  logic                     r_cs_prev;
  logic                     r_sclk_prev;
  logic                     r_armed;
  logic [1:0]               r_mode;
  logic [DATA_W-1:0]        r_hold;
  logic                     r_hold_full;
  logic [DATA_W-1:0]        r_tx_shift;
  logic [DATA_W-1:0]        r_rx_shift;
  logic [CNT_W-1:0]         r_bit_cnt;
  logic [DATA_W-1:0]        r_rx_data;
  logic                     r_rx_valid;
  logic [2:0]               r_err;

  logic w_cs, w_sclk, w_mosi, w_cs_fall;
  logic w_lead, w_trail, w_sample_edge, w_shift_edge;
  logic w_abort, w_overrun, w_underrun, w_oe;

  assign w_cs   = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  assign w_cs_fall = r_armed & r_cs_prev & ~w_cs;

  // Edges are judged against the CPOL level latched for this frame.
  assign w_lead  = (r_sclk_prev == r_mode[1]) && (w_sclk != r_mode[1]);
  assign w_trail = (r_sclk_prev != r_mode[1]) && (w_sclk == r_mode[1]);
  assign w_sample_edge = (r_state == ST_SHIFT) && (r_mode[0] ? w_trail : w_lead);
  assign w_shift_edge  = (r_state == ST_SHIFT) && (r_mode[0] ? w_lead : w_trail);

  assign w_abort    = ((r_state == ST_LOAD) || (r_state == ST_SHIFT)) && w_cs;
  assign w_overrun  = (r_state == ST_DONE) && r_rx_valid && !rx_ready;
  assign w_underrun = (r_state == ST_LOAD) && !r_hold_full;

  // Pin synchronizers, edge-detect history and arming.
  always_ff @(posedge core_clk) begin
    if (srst) begin
      r_cs_sync   <= '1;
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_sync_vld  <= '0;
      r_cs_prev   <= 1'b1;
      r_sclk_prev <= 1'b0;
      r_armed     <= 1'b0;
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_sync_vld  <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};
      r_cs_prev   <= w_cs;
      r_sclk_prev <= w_sclk;
      // The synchronizer's reset value of cs=1 must not arm the block: a
      // reset taken while CS is held low would otherwise see a false fall.
      // Arm only once the synced value comes from a real pin sample.
      if (w_cs && r_sync_vld[SYNC_STAGES-1]) begin
        r_armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge core_clk) begin
    if (srst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_oe         = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_oe = 1'b0;
        if (w_cs_fall && enable) begin
          w_state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_state_next = w_cs ? ST_IDLE : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_cs) begin
          w_state_next = ST_IDLE;
        end else if (w_sample_edge && (r_bit_cnt == CNT_W'(DATA_W - 1))) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_WAIT_CS;
      end
      ST_WAIT_CS: begin
        if (w_cs) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_oe         = 1'b0;
      end
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (srst) begin
      r_mode      <= 2'b00;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_bit_cnt   <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_err       <= '0;
    end else begin
      if ((r_state == ST_IDLE) && w_cs_fall) begin
        r_mode <= cpol_cpha;
      end

      // LOAD empties a full holding register; a write is only possible when
      // it is empty, so the two never collide.
      if ((r_state == ST_LOAD) && r_hold_full) begin
        r_hold_full <= 1'b0;
      end else if (tx_valid && !r_hold_full) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end

      if (r_state == ST_LOAD) begin
        r_tx_shift <= r_hold_full ? r_hold : '0;
        r_bit_cnt  <= '0;
      end

      if (w_sample_edge) begin
        r_rx_shift <= {r_rx_shift[DATA_W-2:0], w_mosi};
        r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
      end

      // With CPHA=1 the first leading edge arrives before any sample; it
      // must not shift, or the MSB would never be presented.
      if (w_shift_edge && (r_bit_cnt != '0)) begin
        r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
      end

      if (r_state == ST_DONE) begin
        if (!w_overrun) begin
          r_rx_data  <= r_rx_shift;
          r_rx_valid <= 1'b1;
        end
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end

      // New error events take priority over a simultaneous clear.
      r_err <= (err_clr ? 3'b000 : r_err) | {w_abort, w_underrun, w_overrun};
    end
  end

  assign tx_ready    = !r_hold_full;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign spi_miso_oe = w_oe;
  assign spi_miso    = w_oe & r_tx_shift[DATA_W-1];
  assign busy        = (r_state != ST_IDLE);
  assign error_flags = {1'b0, r_err};

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// ----------------------------------------------------------------------------
// tb_spi_slave_ctrl
//   Directed bench for spi_slave_ctrl: a bit-banged SPI master drives frames
//   in all four modes; TX/RX handshakes, error flags, abort and mid-frame
//   reset are checked against hand-computed values.
// ----------------------------------------------------------------------------
module tb_spi_slave_ctrl;

  localparam int DW   = 32;
  localparam int SS   = 2;
  localparam int HALF = 5;

  logic          core_clk = 1'b0;
  logic          srst;
  logic          enable;
  logic [1:0]    cpol_cpha;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          err_clr;
  logic          spi_cs_n;
  logic          spi_sclk;
  logic          spi_mosi;
  logic          spi_miso;
  logic          spi_miso_oe;
  logic          busy;
  logic [3:0]    error_flags;

  int checks   = 0;
  int failures = 0;

  always #5 core_clk = ~core_clk;

  spi_slave_ctrl #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
    .core_clk    (core_clk),
    .srst        (srst),
    .enable      (enable),
    .cpol_cpha   (cpol_cpha),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .err_clr     (err_clr),
    .spi_cs_n    (spi_cs_n),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .busy        (busy),
    .error_flags (error_flags)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge core_clk);
  endtask

  task automatic tx_write(input logic [31:0] w);
    @(negedge core_clk);
    tx_data  = w;
    tx_valid = 1'b1;
    @(negedge core_clk);
    tx_valid = 1'b0;
    check_value("tx_ready_drop", {31'b0, tx_ready}, 32'd0);
    $display("tx write 0x%08h", w);
  endtask

  task automatic rx_take();
    @(negedge core_clk);
    rx_ready = 1'b1;
    @(negedge core_clk);
    rx_ready = 1'b0;
    check_value("rx_valid_clr", {31'b0, rx_valid}, 32'd0);
  endtask

  task automatic err_pulse();
    @(negedge core_clk);
    err_clr = 1'b1;
    @(negedge core_clk);
    err_clr = 1'b0;
    check_value("err_cleared", {28'b0, error_flags}, 32'd0);
  endtask

  // Idle SCLK at CPOL, drop CS, and report MISO before the first edge.
  task automatic spi_begin(input logic [1:0] mode, output logic first_bit);
    @(negedge core_clk);
    cpol_cpha = mode;
    spi_sclk  = mode[1];
    tick(4);
    spi_cs_n = 1'b0;
    tick(8);
    first_bit = spi_miso;
  endtask

  // Clock n bits starting from word[31]; MISO is captured at the sample edge.
  task automatic spi_bits(input logic [1:0] mode, input logic [31:0] word,
                          input int n, output logic [31:0] miso_word);
    miso_word = '0;
    for (int i = 0; i < n; i++) begin
      if (!mode[0]) begin
        spi_mosi = word[31-i];
        tick(HALF);
        miso_word = {miso_word[30:0], spi_miso};
        spi_sclk  = ~mode[1];
        tick(HALF);
        spi_sclk  = mode[1];
      end else begin
        spi_sclk = ~mode[1];
        spi_mosi = word[31-i];
        tick(HALF);
        miso_word = {miso_word[30:0], spi_miso};
        spi_sclk  = mode[1];
        tick(HALF);
      end
    end
  endtask

  task automatic spi_end();
    tick(1);
    spi_cs_n = 1'b1;
    tick(8);
  endtask

  task automatic run_frame(input logic [1:0] mode, input logic [31:0] mosi_w,
                           output logic [31:0] miso_w);
    logic fb_l;
    spi_begin(mode, fb_l);
    spi_bits(mode, mosi_w, 32, miso_w);
    spi_end();
    $display("frame mode=%0d mosi=0x%08h miso=0x%08h rx=0x%08h v=%0b err=%04b",
             mode, mosi_w, miso_w, rx_data, rx_valid, error_flags);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  md;
    logic        fb;
    logic [31:0] mw;

    srst = 1'b1; enable = 1'b1; cpol_cpha = 2'b00;
    tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; err_clr = 1'b0;
    spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    tick(3);
    srst = 1'b0;
    check_value("rst_tx_ready", {31'b0, tx_ready}, 32'd1);
    check_value("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
    check_value("rst_rx_data", rx_data, 32'd0);
    check_value("rst_miso", {31'b0, spi_miso}, 32'd0);
    check_value("rst_miso_oe", {31'b0, spi_miso_oe}, 32'd0);
    check_value("rst_busy", {31'b0, busy}, 32'd0);
    check_value("rst_err", {28'b0, error_flags}, 32'd0);
    tick(6);

    // All four modes with the same words.
    for (int m = 0; m < 4; m++) begin
      md = m[1:0];
      tx_write(32'hA5A50F0F);
      spi_begin(md, fb);
      check_value("first_miso", {31'b0, fb}, 32'd1);
      check_value("busy_in_frame", {31'b0, busy}, 32'd1);
      check_value("oe_in_frame", {31'b0, spi_miso_oe}, 32'd1);
      check_value("tx_ready_after_load", {31'b0, tx_ready}, 32'd1);
      spi_bits(md, 32'h12345678, 32, mw);
      spi_end();
      $display("frame mode=%0d mosi=0x12345678 miso=0x%08h rx=0x%08h v=%0b err=%04b",
               md, mw, rx_data, rx_valid, error_flags);
      check_value("mode_miso", mw, 32'hA5A50F0F);
      check_value("mode_rx_data", rx_data, 32'h12345678);
      check_value("mode_rx_valid", {31'b0, rx_valid}, 32'd1);
      check_value("mode_err", {28'b0, error_flags}, 32'd0);
      rx_take();
    end

    // TX underrun: no word written before the frame.
    run_frame(2'b00, 32'hCAFEF00D, mw);
    check_value("under_miso", mw, 32'd0);
    check_value("under_err", {28'b0, error_flags}, 32'h2);
    check_value("under_rx_valid", {31'b0, rx_valid}, 32'd1);
    check_value("under_rx_data", rx_data, 32'hCAFEF00D);
    err_pulse();
    rx_take();

    // RX overrun: two frames with nothing consumed.
    tx_write(32'h0F0F0F0F);
    run_frame(2'b00, 32'h11111111, mw);
    tx_write(32'hF0F0F0F0);
    run_frame(2'b00, 32'h22222222, mw);
    check_value("over_miso2", mw, 32'hF0F0F0F0);
    check_value("over_rx_data", rx_data, 32'h11111111);
    check_value("over_rx_valid", {31'b0, rx_valid}, 32'd1);
    check_value("over_err", {28'b0, error_flags}, 32'h1);
    err_pulse();
    rx_take();

    // Disabled frame is ignored.
    enable = 1'b0;
    spi_begin(2'b00, fb);
    check_value("dis_busy", {31'b0, busy}, 32'd0);
    check_value("dis_oe", {31'b0, spi_miso_oe}, 32'd0);
    spi_bits(2'b00, 32'h55AA55AA, 32, mw);
    spi_end();
    $display("disabled frame rx_valid=%0b", rx_valid);
    check_value("dis_rx_valid", {31'b0, rx_valid}, 32'd0);
    enable = 1'b1;

    // Abort after 10 bits.
    tx_write(32'hA5A50F0F);
    spi_begin(2'b00, fb);
    spi_bits(2'b00, 32'h12345678, 10, mw);
    check_value("abort_partial_miso", mw, 32'h296);
    @(negedge core_clk);
    spi_cs_n = 1'b1;
    repeat (SS) @(posedge core_clk);
    #1;
    check_value("abort_busy_hold", {31'b0, busy}, 32'd1);
    @(posedge core_clk);
    #1;
    check_value("abort_busy_fall", {31'b0, busy}, 32'd0);
    tick(8);
    $display("abort err=%04b rx_valid=%0b", error_flags, rx_valid);
    check_value("abort_err", {28'b0, error_flags}, 32'h4);
    check_value("abort_rx_valid", {31'b0, rx_valid}, 32'd0);
    err_pulse();
    tx_write(32'hA5A50F0F);
    run_frame(2'b00, 32'h87654321, mw);
    check_value("post_abort_miso", mw, 32'hA5A50F0F);
    check_value("post_abort_rx", rx_data, 32'h87654321);
    check_value("post_abort_valid", {31'b0, rx_valid}, 32'd1);
    check_value("post_abort_err", {28'b0, error_flags}, 32'd0);
    rx_take();

    // Reset in the middle of a frame while CS stays low.
    tx_write(32'hA5A50F0F);
    spi_begin(2'b00, fb);
    spi_bits(2'b00, 32'h12345678, 10, mw);
    @(negedge core_clk);
    srst = 1'b1;
    @(negedge core_clk);
    srst = 1'b0;
    check_value("srst_busy", {31'b0, busy}, 32'd0);
    spi_bits(2'b00, 32'h12345678 << 10, 22, mw);
    check_value("srst_rest_busy", {31'b0, busy}, 32'd0);
    check_value("srst_rest_oe", {31'b0, spi_miso_oe}, 32'd0);
    check_value("srst_rx_valid", {31'b0, rx_valid}, 32'd0);
    spi_end();
    $display("srst frame ignored rx_valid=%0b tx_ready=%0b", rx_valid, tx_ready);
    check_value("srst_tx_ready", {31'b0, tx_ready}, 32'd1);
    tx_write(32'h3C3C3C3C);
    run_frame(2'b00, 32'hDEADBEEF, mw);
    check_value("post_srst_miso", mw, 32'h3C3C3C3C);
    check_value("post_srst_rx", rx_data, 32'hDEADBEEF);
    check_value("post_srst_valid", {31'b0, rx_valid}, 32'd1);
    check_value("post_srst_err", {28'b0, error_flags}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
